// File: rtl/pio_gpio_pkg.sv
// Shared constants for the edge-capturing PIO: register offsets, bus widths, edge encodings.
package pio_gpio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_OUT      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_gpio_edge_if.sv
// Avalon-MM slave bus bundle for the PIO register block.
interface pio_gpio_edge_if;
  import pio_gpio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_sync2.sv
// Two-flop synchroniser for asynchronous input bits.
module pio_sync2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Both stages clear on reset so the downstream delay register starts equal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pio_gpio_edge.sv
// PIO with output register, set/clear aliases, sticky edge capture and masked level IRQ.
module pio_gpio_edge
  import pio_gpio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           EDGE_TYPE   = EDGE_RISE,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  pio_gpio_edge_if.slave        bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  // Elaboration guards on the parameter ranges.
  if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
    $error("pio_gpio_edge: DATA_WIDTH must be in 1..32");
  end
  if (EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
    $error("pio_gpio_edge: EDGE_TYPE must be 0, 1 or 2");
  end

  logic [DATA_WIDTH-1:0] sync, prev, edge_det;
  logic [DATA_WIDTH-1:0] out_reg, mask, edgecap;
  logic [DATA_WIDTH-1:0] out_nxt, mask_nxt, edgecap_nxt, clr, wd;
  logic                  wr_en;
  logic                  unused_wd;

  assign unused_wd = ^bus.writedata;
  assign out_port  = out_reg;

  pio_sync2 #(.WIDTH(DATA_WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync)
  );

  // Per-bit edge detector selected at elaboration.
  if (EDGE_TYPE == EDGE_FALL) begin : g_fall
    always_comb edge_det = ~sync & prev;
  end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
    always_comb edge_det = sync ^ prev;
  end else begin : g_rise
    always_comb edge_det = sync & ~prev;
  end

  // Register-write decode; a new edge wins over a same-cycle write-1-to-clear.
  always_comb begin
    wr_en    = bus.chipselect & ~bus.write_n;
    wd       = DATA_WIDTH'(bus.writedata);
    out_nxt  = out_reg;
    mask_nxt = mask;
    clr      = '0;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA, ADDR_OUT: out_nxt  = wd;
        ADDR_IRQMASK:        mask_nxt = wd;
        ADDR_EDGECAP:        clr      = wd;
        ADDR_OUTSET:         out_nxt  = out_reg | wd;
        ADDR_OUTCLEAR:       out_nxt  = out_reg & ~wd;
        default:             ;
      endcase
    end
    edgecap_nxt = (edgecap & ~clr) | edge_det;
  end

  // State registers; irq is derived from the registered capture/mask pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg <= RESET_VALUE;
      mask    <= '0;
      edgecap <= '0;
      prev    <= '0;
      irq     <= 1'b0;
    end else begin
      out_reg <= out_nxt;
      mask    <= mask_nxt;
      edgecap <= edgecap_nxt;
      prev    <= sync;
      irq     <= |(edgecap & mask);
    end
  end

  // Zero-wait-state combinational readback, zero-extended.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:                          bus.readdata = BUS_W'(sync);
      ADDR_OUT, ADDR_OUTSET, ADDR_OUTCLEAR: bus.readdata = BUS_W'(out_reg);
      ADDR_IRQMASK:                       bus.readdata = BUS_W'(mask);
      ADDR_EDGECAP:                       bus.readdata = BUS_W'(edgecap);
      default:                            ;
    endcase
  end

endmodule

// File: tb/tb_pio_gpio_edge.sv
// Bench for pio_gpio_edge: three instances (rising / any+nonzero reset value / falling).
module tb_pio_gpio_edge;
  import pio_gpio_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] in0, in1, in2;
  logic [7:0] out0, out1, out2;
  logic       irq0, irq1, irq2;

  int total;
  int bad;

  pio_gpio_edge_if bus0 ();
  pio_gpio_edge_if bus1 ();
  pio_gpio_edge_if bus2 ();

  pio_gpio_edge #(.DATA_WIDTH(8), .EDGE_TYPE(EDGE_RISE), .RESET_VALUE(8'h00)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .in_port(in0), .out_port(out0), .irq(irq0));
  pio_gpio_edge #(.DATA_WIDTH(8), .EDGE_TYPE(EDGE_ANY), .RESET_VALUE(8'h3C)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .in_port(in1), .out_port(out1), .irq(irq1));
  pio_gpio_edge #(.DATA_WIDTH(8), .EDGE_TYPE(EDGE_FALL), .RESET_VALUE(8'h00)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .in_port(in2), .out_port(out2), .irq(irq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    bit          wr;
    bit          rd;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  inp;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic        exp_irq;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    int          sel;
    bit          chk_rd;
    logic [31:0] rd;
    logic [7:0]  out;
    logic        irq;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  logic [31:0] rd_act;

  function automatic void add(int sel, bit wr, bit rd, logic [2:0] addr, logic [31:0] wd,
                              logic [7:0] inp, logic [31:0] exp_rd, logic [7:0] exp_out,
                              logic exp_irq, string name);
    vec_t v;
    v.sel = sel; v.wr = wr; v.rd = rd; v.addr = addr; v.wd = wd; v.inp = inp;
    v.exp_rd = exp_rd; v.exp_out = exp_out; v.exp_irq = exp_irq; v.name = name;
    tbl.push_back(v);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [31:0] d);
    bus0.address = a; bus0.writedata = d; bus0.write_n = wn; bus0.chipselect = cs && (sel == 0);
    bus1.address = a; bus1.writedata = d; bus1.write_n = wn; bus1.chipselect = cs && (sel == 1);
    bus2.address = a; bus2.writedata = d; bus2.write_n = wn; bus2.chipselect = cs && (sel == 2);
  endtask

  task automatic set_in(input int sel, input logic [7:0] v);
    case (sel)
      0: in0 = v;
      1: in1 = v;
      default: in2 = v;
    endcase
  endtask

  function automatic logic [31:0] rd_of(int sel);
    case (sel)
      0: return bus0.readdata;
      1: return bus1.readdata;
      default: return bus2.readdata;
    endcase
  endfunction

  function automatic logic [7:0] out_of(int sel);
    case (sel)
      0: return out0;
      1: return out1;
      default: return out2;
    endcase
  endfunction

  function automatic logic irq_of(int sel);
    case (sel)
      0: return irq0;
      1: return irq1;
      default: return irq2;
    endcase
  endfunction

  // One bus cycle: drive at negedge, sample readdata mid-low, check state after posedge.
  task automatic step(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    drive(v.sel, v.wr | v.rd, ~v.wr, v.addr, v.wd);
    set_in(v.sel, v.inp);
    e.name = $sformatf("v%0d_%s", idx, v.name);
    e.sel = v.sel; e.chk_rd = v.rd; e.rd = v.exp_rd; e.out = v.exp_out; e.irq = v.exp_irq;
    sb.push_back(e);
    #2;
    rd_act = rd_of(v.sel);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (got.chk_rd) cmp({got.name, "_rd"}, rd_act, got.rd);
    cmp({got.name, "_out"}, 32'(out_of(got.sel)), 32'(got.out));
    cmp({got.name, "_irq"}, 32'(irq_of(got.sel)), 32'(got.irq));
  endtask

  // Every offset of dut0 and dut1 read while state is at reset values.
  task automatic read_all(input string tag);
    for (int a = 0; a < 8; a++) begin
      logic [2:0]  a3;
      logic [31:0] e1;
      a3 = 3'(a);
      drive(0, 1'b0, 1'b1, a3, 32'h0);
      #1;
      e1 = (a3 == ADDR_OUT || a3 == ADDR_OUTSET || a3 == ADDR_OUTCLEAR) ? 32'h3C : 32'h0;
      cmp($sformatf("%s_d0_rd%0d", tag, a), bus0.readdata, 32'h0);
      cmp($sformatf("%s_d1_rd%0d", tag, a), bus1.readdata, e1);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    in0 = '0; in1 = '0; in2 = '0;
    drive(0, 1'b0, 1'b1, 3'd0, 32'h0);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_out0", 32'(out0), 32'h00);
    cmp("rst_irq0", 32'(irq0), 32'h0);
    cmp("rst_out1", 32'(out1), 32'h3C);
    cmp("rst_irq1", 32'(irq1), 32'h0);
    cmp("rst_out2", 32'(out2), 32'h00);
    read_all("rst");
    reset = 1'b0;

    // dut0: output path, register map, unmapped writes
    add(0,1,0,3'd0,32'hA5,8'h00,0,8'hA5,0,"wr_data");
    add(0,1,0,3'd4,32'h0A,8'h00,0,8'hAF,0,"wr_outset");
    add(0,1,0,3'd5,32'h81,8'h00,0,8'h2E,0,"wr_outclr");
    add(0,0,1,3'd1,0,8'h00,32'h2E,8'h2E,0,"rd_out");
    add(0,0,1,3'd4,0,8'h00,32'h2E,8'h2E,0,"rd_outset");
    add(0,0,1,3'd5,0,8'h00,32'h2E,8'h2E,0,"rd_outclr");
    add(0,0,1,3'd6,0,8'h00,32'h00,8'h2E,0,"rd_6");
    add(0,0,1,3'd7,0,8'h00,32'h00,8'h2E,0,"rd_7");
    add(0,0,1,3'd0,0,8'h00,32'h00,8'h2E,0,"rd_data");
    add(0,0,1,3'd2,0,8'h00,32'h00,8'h2E,0,"rd_mask");
    add(0,0,1,3'd3,0,8'h00,32'h00,8'h2E,0,"rd_ecap");
    add(0,1,0,3'd6,32'hFF,8'h00,0,8'h2E,0,"wr_6");
    add(0,1,0,3'd7,32'hFF,8'h00,0,8'h2E,0,"wr_7");
    add(0,0,1,3'd2,0,8'h00,32'h00,8'h2E,0,"rd_mask_un");
    add(0,0,1,3'd3,0,8'h00,32'h00,8'h2E,0,"rd_ecap_un");
    add(0,1,0,3'd1,32'h55,8'h00,0,8'h55,0,"wr_out");
    add(0,0,1,3'd1,0,8'h00,32'h55,8'h55,0,"rd_out2");
    add(0,1,0,3'd2,32'h04,8'h00,0,8'h55,0,"wr_mask");
    add(0,0,1,3'd2,0,8'h00,32'h04,8'h55,0,"rd_mask2");
    add(0,1,0,3'd0,32'hFFFF_FF00,8'h00,0,8'h00,0,"wr_wide");
    add(0,0,1,3'd0,0,8'h00,32'h00,8'h00,0,"rd_data2");
    // dut0: rising edge on bit2 -> capture 3 cycles later, irq one after
    add(0,0,0,3'd0,0,8'h04,0,8'h00,0,"in_rise");
    add(0,0,1,3'd0,0,8'h04,32'h00,8'h00,0,"data_lag1");
    add(0,0,1,3'd3,0,8'h04,32'h00,8'h00,0,"ecap_early");
    add(0,0,1,3'd3,0,8'h04,32'h04,8'h00,1,"ecap_set");
    add(0,0,1,3'd0,0,8'h04,32'h04,8'h00,1,"data_sync");
    add(0,1,0,3'd3,32'h04,8'h04,0,8'h00,1,"ecap_w1c");
    add(0,0,1,3'd3,0,8'h04,32'h00,8'h00,0,"ecap_clr");
    // dut0: falling edge ignored in rising mode
    add(0,0,0,3'd0,0,8'h00,0,8'h00,0,"in_fall");
    add(0,0,1,3'd3,0,8'h00,32'h00,8'h00,0,"nofall1");
    add(0,0,1,3'd3,0,8'h00,32'h00,8'h00,0,"nofall2");
    add(0,0,1,3'd3,0,8'h00,32'h00,8'h00,0,"nofall3");
    add(0,0,1,3'd3,0,8'h00,32'h00,8'h00,0,"nofall4");
    // dut0: edge on bit0 in the same cycle as its clear; masked bit keeps irq low
    add(0,0,0,3'd0,0,8'h01,0,8'h00,0,"soc_in");
    add(0,0,1,3'd3,0,8'h01,32'h00,8'h00,0,"soc_pre");
    add(0,1,0,3'd3,32'h01,8'h01,0,8'h00,0,"soc_w1c");
    add(0,0,1,3'd3,0,8'h01,32'h01,8'h00,0,"soc_kept");
    add(0,0,1,3'd3,0,8'h01,32'h01,8'h00,0,"soc_masked");
    add(0,1,0,3'd3,32'h01,8'h01,0,8'h00,0,"soc_clr");
    add(0,0,1,3'd3,0,8'h01,32'h00,8'h00,0,"soc_gone");
    // dut0: out_port=0xFF and irq=1 ahead of the asynchronous reset
    add(0,1,0,3'd0,32'hFF,8'h05,0,8'hFF,0,"pre_rst_wr");
    add(0,0,0,3'd0,0,8'h05,0,8'hFF,0,"pre_rst_1");
    add(0,0,0,3'd0,0,8'h05,0,8'hFF,0,"pre_rst_2");
    add(0,0,0,3'd0,0,8'h05,0,8'hFF,1,"pre_rst_irq");

    // dut1 (any edge, reset value 0x3C)
    add(1,0,0,3'd0,0,8'h00,0,8'h3C,0,"d1_rv");
    add(1,0,1,3'd1,0,8'h00,32'h3C,8'h3C,0,"d1_rd_rv");
    add(1,1,0,3'd4,32'h03,8'h00,0,8'h3F,0,"d1_set");
    add(1,1,0,3'd5,32'h30,8'h00,0,8'h0F,0,"d1_clr");
    add(1,0,1,3'd5,0,8'h00,32'h0F,8'h0F,0,"d1_rd");
    add(1,0,0,3'd0,0,8'h80,0,8'h0F,0,"d1_pulse_hi");
    add(1,0,0,3'd0,0,8'h00,0,8'h0F,0,"d1_pulse_lo");
    add(1,0,1,3'd3,0,8'h00,32'h00,8'h0F,0,"d1_pulse_early");
    add(1,0,1,3'd3,0,8'h00,32'h80,8'h0F,0,"d1_pulse_cap");
    add(1,1,0,3'd2,32'h01,8'h00,0,8'h0F,0,"d1_mask");
    add(1,0,0,3'd0,0,8'h00,0,8'h0F,0,"d1_noirq1");
    add(1,0,1,3'd3,0,8'h00,32'h80,8'h0F,0,"d1_noirq2");
    add(1,1,0,3'd3,32'h80,8'h00,0,8'h0F,0,"d1_w1c");
    add(1,0,1,3'd3,0,8'h00,32'h00,8'h0F,0,"d1_cleared");
    add(1,0,0,3'd0,0,8'h80,0,8'h0F,0,"d1_rise");
    add(1,0,0,3'd0,0,8'h80,0,8'h0F,0,"d1_rise_w");
    add(1,0,1,3'd3,0,8'h80,32'h00,8'h0F,0,"d1_rise_early");
    add(1,0,1,3'd3,0,8'h80,32'h80,8'h0F,0,"d1_rise_cap");
    add(1,1,0,3'd3,32'h80,8'h80,0,8'h0F,0,"d1_rise_w1c");
    add(1,0,1,3'd3,0,8'h80,32'h00,8'h0F,0,"d1_rise_clr");
    add(1,0,0,3'd0,0,8'h00,0,8'h0F,0,"d1_fall");
    add(1,0,0,3'd0,0,8'h00,0,8'h0F,0,"d1_fall_w");
    add(1,0,1,3'd3,0,8'h00,32'h00,8'h0F,0,"d1_fall_early");
    add(1,0,1,3'd3,0,8'h00,32'h80,8'h0F,0,"d1_fall_cap");
    add(1,1,0,3'd3,32'h80,8'h00,0,8'h0F,0,"d1_fall_w1c");
    add(1,0,1,3'd3,0,8'h00,32'h00,8'h0F,0,"d1_fall_clr");

    // dut2 (falling edge)
    add(2,1,0,3'd2,32'h01,8'h01,0,8'h00,0,"d2_mask");
    add(2,0,0,3'd0,0,8'h01,0,8'h00,0,"d2_hi1");
    add(2,0,0,3'd0,0,8'h01,0,8'h00,0,"d2_hi2");
    add(2,0,1,3'd3,0,8'h01,32'h00,8'h00,0,"d2_norise");
    add(2,0,0,3'd0,0,8'h00,0,8'h00,0,"d2_lo");
    add(2,0,0,3'd0,0,8'h00,0,8'h00,0,"d2_lo_w");
    add(2,0,1,3'd3,0,8'h00,32'h00,8'h00,0,"d2_fall_early");
    add(2,0,1,3'd3,0,8'h00,32'h01,8'h00,1,"d2_fall_cap");
    add(2,0,1,3'd2,0,8'h00,32'h01,8'h00,1,"d2_irq_hold");

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Asynchronous reset between edges, with a write on the bus in the same cycle
    @(negedge clk);
    drive(0, 1'b1, 1'b0, ADDR_DATA, 32'h77);
    #2 reset = 1'b1;
    #1;
    cmp("arst_out0", 32'(out0), 32'h00);
    cmp("arst_irq0", 32'(irq0), 32'h0);
    cmp("arst_out1", 32'(out1), 32'h3C);
    cmp("arst_irq2", 32'(irq2), 32'h0);
    @(posedge clk);
    #1;
    cmp("arst_wr_abort", 32'(out0), 32'h00);
    read_all("arst");
    in0 = '0; in1 = '0; in2 = '0;
    @(negedge clk);
    reset = 1'b0;

    // No spurious capture right after reset release
    tbl.delete();
    add(0,0,1,3'd3,0,8'h00,32'h00,8'h00,0,"post_rst1");
    add(0,0,1,3'd3,0,8'h00,32'h00,8'h00,0,"post_rst2");
    add(0,0,1,3'd3,0,8'h00,32'h00,8'h00,0,"post_rst3");
    add(0,0,1,3'd2,0,8'h00,32'h00,8'h00,0,"post_rst_mask");
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1000 + i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_gpio_edge.md
PIO_GPIO_EDGE -- requirements
Module: pio_gpio_edge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the port width in bits; the legal range is 1..32.
REQ-002 SHALL have parameter EDGE_TYPE, default 0, meaning the capture edge: 0 = rising, 1 = falling, 2 = any.
REQ-003 SHALL have parameter RESET_VALUE, default 0, meaning the reset value of the output register, DATA_WIDTH bits wide.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 SHALL have port address, input, 3 bits: the Avalon-MM word address.
REQ-007 SHALL have port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-008 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-009 SHALL have port writedata, input, 32 bits: write data.
REQ-010 SHALL have port readdata, output, 32 bits: read data.
REQ-011 SHALL have port in_port, input, DATA_WIDTH bits: asynchronous external inputs.
REQ-012 SHALL have port out_port, output, DATA_WIDTH bits: the output register value.
REQ-013 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-014 SHALL use this register map (word offsets): 0 DATA, 1 OUT, 2 IRQMASK, 3 EDGECAP, 4 OUTSET, 5 OUTCLEAR; offsets 6-7 are unmapped.
REQ-015 SHALL treat a write as the clock cycle in which chipselect=1 and write_n=0; each write takes effect at the next rising edge.
REQ-016 SHALL handle DATA writes as: out_reg <= writedata[DATA_WIDTH-1:0].
REQ-017 SHALL handle OUT writes identically to DATA writes.
REQ-018 SHALL handle OUTSET writes as: out_reg <= out_reg | wd; OUTCLEAR writes as: out_reg <= out_reg & ~wd.
REQ-019 SHALL handle IRQMASK writes as: mask <= wd.
REQ-020 SHALL make EDGECAP write-1-to-clear: bits where wd=1 clear and bits where wd=0 hold.
REQ-021 SHALL ignore writes to unmapped offsets.
REQ-022 SHALL make readdata combinational on address, with zero wait states and zero-extended to 32 bits:
- DATA -> synchronised input
- OUT, OUTSET, OUTCLEAR -> out_reg
- IRQMASK -> mask
- EDGECAP -> edgecap
- unmapped offsets -> 0
REQ-023 SHALL give reads no side effects.
REQ-024 SHALL pass in_port through a 2-FF synchroniser (sync) followed by a delay register (prev); the DATA readback lags in_port by 2 cycles.
REQ-025 SHALL detect edges per bit as: rising = sync & ~prev; falling = ~sync & prev; any = sync ^ prev, selected by EDGE_TYPE.
REQ-026 SHALL make a detected edge set its edgecap bit at the next rising edge, 3 cycles after the in_port change; the bit is sticky until cleared.
REQ-027 SHALL give set priority when an edge is detected on a bit in the same cycle as a write-1-to-clear of that bit: the bit ends at 1.
REQ-028 SHALL register irq as irq <= |(edgecap & mask), so irq asserts 1 cycle after the edgecap bit sets.
REQ-029 SHALL drive out_port directly from out_reg, with no combinational path from writedata.
REQ-030 SHALL never let an edge be detected on the first cycle after reset deasserts, because sync and prev reset to equal values.

Reset
REQ-031 SHALL, while reset=1 and independent of clk, hold: out_reg = RESET_VALUE, mask = 0, edgecap = 0, sync stages = 0, prev = 0, irq = 0.
REQ-032 SHALL, when reset asserts mid-operation, abort any write in the same cycle and force all state to its reset values within the same cycle.
REQ-033 SHALL hold readdata = 0 during reset for every address except DATA (reads 0 because sync = 0) and OUT/OUTSET/OUTCLEAR (read RESET_VALUE).

Structure
REQ-034 SHALL take the register offset constants and the EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY) from the shared package pio_gpio_pkg.
REQ-035 SHALL place the 2-FF synchroniser in the sub-module pio_sync2, parametrised by width, with async active-high reset; it is instantiated once.
REQ-036 SHALL reject DATA_WIDTH outside 1..32 and EDGE_TYPE greater than 2 at elaboration.

Verification
REQ-037 SHALL cover, at DATA_WIDTH=8, reset -> out_port=0x00, irq=0, and reads at offsets 0-7 return 0.
REQ-038 SHALL cover the read-modify-free output path: write DATA=0xA5, then OUTSET=0x0A, then OUTCLEAR=0x81 -> out_port goes 0xA5, 0xAF, 0x2E, and offset 1 reads 0x2E.
REQ-039 SHALL cover rising-edge capture and interrupt with EDGE_TYPE=0, mask=0x04: in_port bit2 0->1 -> EDGECAP=0x04 3 cycles later and irq=1 1 cycle after that; write EDGECAP=0x04 -> irq=0.
REQ-040 SHALL cover set-over-clear: an edge on bit0 coincident with EDGECAP write 0x01 -> EDGECAP bit0 remains 1.
REQ-041 SHALL cover EDGE_TYPE=2 with a 1-cycle in_port pulse on bit7 held over 2 cycles -> EDGECAP=0x80, and a masked bit never raises irq.
REQ-042 SHALL cover reset asserted between clock edges while out_port=0xFF and irq=1 -> out_port=RESET_VALUE and irq=0 immediately, not waiting for clk.
